// File: rtl/sdram_wr_fifo.sv
// -----------------------------------------------------------------------------
// sdram_wr_fifo
//
// Upstream write-data buffer for the SDRAM write path. User words are stored
// in a first-word-fall-through FIFO. Once at least one full burst is buffered,
// a single-cycle wr_trig asks the write module to start a burst. The write
// module then pops exactly BURST_LEN words with wr_data_req. Each word is
// already on wr_data in the cycle it is requested, so it can go straight onto
// the SDRAM DQ bus.
//
// Optional build macro:
//   SDRAM_WR_FIFO_AFULL_EN  adds parameter AFULL_TH and output afull
//                           (registered level >= AFULL_TH), so the user can
//                           throttle before the FIFO is completely full.
//
// Ports:
//   sclk         in   system clock, rising edge
//   s_rst_n      in   asynchronous active-low reset
//   din_vld      in   user push strobe
//   din          in   user write word
//   din_rdy      out  registered "not full"; push accepted on din_vld & din_rdy
//   wr_trig      out  one-cycle burst request to the write module
//   wr_data_req  in   pop strobe, one word per high cycle
//   wr_data      out  FWFT head word (holds last popped word while empty)
//   level        out  registered word count
//   ovf          out  sticky: push attempted while full
//   udf          out  sticky: pop attempted while empty
//   afull        out  (macro only) level >= AFULL_TH
//
// Burst FSM:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no burst outstanding; wait for level >= BURST_LEN
//   TRIG    | wr_trig high for this single cycle; clear pop counter
//   BUSY    | burst outstanding; count pops, back to IDLE on the last one
// -----------------------------------------------------------------------------
module sdram_wr_fifo #(
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 512,
   parameter int AW        = 9,
   parameter int BURST_LEN = 4
`ifdef SDRAM_WR_FIFO_AFULL_EN
   ,
   parameter int AFULL_TH  = DEPTH - BURST_LEN
`endif
) (
   input  logic              sclk,
   input  logic              s_rst_n,
   input  logic              din_vld,
   input  logic [DATA_W-1:0] din,
   output logic              din_rdy,
   output logic              wr_trig,
   input  logic              wr_data_req,
   output logic [DATA_W-1:0] wr_data,
   output logic [AW:0]       level,
   output logic              ovf,
   output logic              udf
`ifdef SDRAM_WR_FIFO_AFULL_EN
   ,
   output logic              afull
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TRIG = 2'd1,
      ST_BUSY = 2'd2
   } state_t;

   localparam int              CW        = $clog2(BURST_LEN + 1);
   localparam logic [AW:0]     PTR_ONE   = (AW + 1)'(1);
   localparam logic [AW:0]     BURST_LV  = (AW + 1)'(BURST_LEN);
   localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]   BURST_CNT = CW'(BURST_LEN);

   // storage
   logic [DATA_W-1:0] mem [DEPTH];

   // pointer / flag state
   logic [AW:0]       wr_ptr_q,  wr_ptr_d;
   logic [AW:0]       rd_ptr_q,  rd_ptr_d;
   logic [AW:0]       level_q,   level_d;
   logic              din_rdy_q, din_rdy_d;
   logic              ovf_q,     ovf_d;
   logic              udf_q,     udf_d;
   logic [DATA_W-1:0] last_q,    last_d;

   // burst FSM state
   state_t            state_q,   state_d;
   logic [CW-1:0]     pop_cnt_q, pop_cnt_d;
   logic              trig;

   logic              empty;
   logic              full_q;
   logic              full_d;
   logic              push_ok;
   logic              pop_ok;
   logic [DATA_W-1:0] head;

   // level_q always equals wr_ptr_q - rd_ptr_q, so it doubles as the
   // registered empty indication.
   assign empty   = (level_q == '0);
   assign full_q  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // din_rdy_q is held low in reset, so nothing is accepted until the first
   // edge after release even though the pointers already say "empty".
   assign push_ok = din_vld & din_rdy_q;
   assign pop_ok  = wr_data_req & ~empty;

   assign head    = mem[rd_ptr_q[AW-1:0]];

   // -------------------------------------------------------------------------
   // Pointer, level and flag next-state
   // -------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      last_d   = last_q;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (din_vld && full_q) begin
         ovf_d = 1'b1;
      end

      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         // keep a copy so wr_data can hold the last word once we run dry
         last_d   = head;
      end
      if (wr_data_req && empty) begin
         udf_d = 1'b1;
      end

      full_d    = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      din_rdy_d = ~full_d;
      level_d   = wr_ptr_d - rd_ptr_d;
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         din_rdy_q <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         last_q    <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         din_rdy_q <= din_rdy_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         last_q    <= last_d;
      end
   end

   // RAM array is not reset; the pointers define which entries are live.
   always_ff @(posedge sclk) begin
      if (push_ok) begin
         mem[wr_ptr_q[AW-1:0]] <= din;
      end
   end

   // -------------------------------------------------------------------------
   // Burst FSM
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      pop_cnt_d = pop_cnt_q;
      trig      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (level_q >= BURST_LV) begin
               state_d = ST_TRIG;
            end
         end
         ST_TRIG: begin
            trig      = 1'b1;
            pop_cnt_d = '0;
            state_d   = ST_BUSY;
         end
         ST_BUSY: begin
            // pops in IDLE/TRIG are serviced by the FIFO but never counted
            if (pop_ok) begin
               pop_cnt_d = pop_cnt_q + CNT_ONE;
               if ((pop_cnt_q + CNT_ONE) == BURST_CNT) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q   <= ST_IDLE;
         pop_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pop_cnt_q <= pop_cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign din_rdy = din_rdy_q;
   assign wr_trig = trig;
   assign wr_data = empty ? last_q : head;
   assign level   = level_q;
   assign ovf     = ovf_q;
   assign udf     = udf_q;

`ifdef SDRAM_WR_FIFO_AFULL_EN
   assign afull   = (level_q >= (AW + 1)'(AFULL_TH));
`endif

endmodule

// File: tb/tb_sdram_wr_fifo.sv
module tb_sdram_wr_fifo;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 512;
   localparam int AW     = 9;
   localparam int BL     = 4;

   logic              sclk        = 1'b0;
   logic              s_rst_n     = 1'b0;
   logic              din_vld     = 1'b0;
   logic [DATA_W-1:0] din         = '0;
   logic              wr_data_req = 1'b0;
   logic              din_rdy;
   logic              wr_trig;
   logic [DATA_W-1:0] wr_data;
   logic [AW:0]       level;
   logic              ovf;
   logic              udf;
`ifdef SDRAM_WR_FIFO_AFULL_EN
   logic              afull;
`endif

   sdram_wr_fifo #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .AW        (AW),
      .BURST_LEN (BL)
   ) dut (
      .sclk        (sclk),
      .s_rst_n     (s_rst_n),
      .din_vld     (din_vld),
      .din         (din),
      .din_rdy     (din_rdy),
      .wr_trig     (wr_trig),
      .wr_data_req (wr_data_req),
      .wr_data     (wr_data),
      .level       (level),
      .ovf         (ovf),
      .udf         (udf)
`ifdef SDRAM_WR_FIFO_AFULL_EN
      ,
      .afull       (afull)
`endif
   );

   always #5 sclk = ~sclk;

   int                n_cmp = 0;
   int                n_bad = 0;

   // scoreboard / reference model
   logic [DATA_W-1:0] exp_q[$];
   bit                m_ovf    = 1'b0;
   bit                m_udf    = 1'b0;
   logic [DATA_W-1:0] last_pop = '0;

   // trigger monitor state
   int                trig_cnt  = 0;
   int                cyc       = 0;
   int                last_cyc  = 0;
   bit                have_last = 1'b0;
   bit                prev_trig = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Sampled on the falling edge; the stimulus checks run 1 time unit later,
   // so trig_cnt is always up to date when they look at it.
   always @(negedge sclk) begin
      cyc++;
      if (wr_trig) begin
         chk("trig_width", {31'd0, prev_trig}, 32'd0);
         if (have_last) begin
            chk("trig_gap", {31'd0, ((cyc - last_cyc) >= BL + 2)}, 32'd1);
         end
         have_last = 1'b1;
         last_cyc  = cyc;
         trig_cnt++;
      end
      prev_trig = wr_trig;
   end

   // One clock of stimulus. Called at negedge+1; returns at the next negedge+1.
   task automatic step(input logic vld, input logic [DATA_W-1:0] d, input logic req);
      int sz;
      din_vld     = vld;
      din         = d;
      wr_data_req = req;
      if (req && exp_q.size() > 0) begin
         chk("wr_data", 32'(wr_data), 32'(exp_q[0]));
      end
      @(posedge sclk);
      sz = exp_q.size();
      if (vld && sz == DEPTH) m_ovf = 1'b1;
      if (req && sz == 0)     m_udf = 1'b1;
      if (req && sz > 0)      last_pop = exp_q.pop_front();
      if (vld && sz < DEPTH)  exp_q.push_back(d);
      @(negedge sclk);
      #1;
      din_vld     = 1'b0;
      wr_data_req = 1'b0;
      chk("level",   32'(level), 32'(exp_q.size()));
      chk("din_rdy", {31'd0, din_rdy}, {31'd0, (exp_q.size() < DEPTH)});
      chk("ovf",     {31'd0, ovf}, {31'd0, m_ovf});
      chk("udf",     {31'd0, udf}, {31'd0, m_udf});
   endtask

   task automatic push_word(input logic [DATA_W-1:0] d);
      step(1'b1, d, 1'b0);
   endtask

   task automatic pop_word();
      step(1'b0, '0, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
   endtask

   // Wait (bounded) for the trigger count to reach target, then one more idle
   // cycle so the following pops land in the BUSY state.
   task automatic wait_trig(input int target);
      int n;
      n = 0;
      while (trig_cnt < target && n < 20) begin
         idle(1);
         n++;
      end
      chk("trig_seen", 32'(trig_cnt), 32'(target));
      idle(1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_din_rdy"}, {31'd0, din_rdy}, 32'd0);
      chk({tag, "_wr_trig"}, {31'd0, wr_trig}, 32'd0);
      chk({tag, "_level"},   32'(level), 32'd0);
      chk({tag, "_ovf"},     {31'd0, ovf}, 32'd0);
      chk({tag, "_udf"},     {31'd0, udf}, 32'd0);
      chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
   endtask

   // Asserts reset mid-cycle, checks everything cleared at once, releases
   // on the next falling edge and runs one cycle so din_rdy comes up.
   task automatic do_reset(input string tag);
      din_vld     = 1'b0;
      wr_data_req = 1'b0;
      #2;
      s_rst_n = 1'b0;
      #1;
      chk_zero(tag);
      exp_q.delete();
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
      last_pop  = '0;
      have_last = 1'b0;
      @(negedge sclk);
      #1;
      s_rst_n = 1'b1;
      idle(1);
   endtask

   initial begin
      int base;

      // reset values
      repeat (3) @(negedge sclk);
      #1;
      chk_zero("rst");
      s_rst_n = 1'b1;
      idle(1);

      // first burst: three words do not trigger, the fourth does
      push_word(16'h1111);
      push_word(16'h2222);
      push_word(16'h3333);
      idle(2);
      chk("trig_below_burst", 32'(trig_cnt), 32'd0);
      push_word(16'h4444);
      wait_trig(1);
      repeat (BL) pop_word();
      idle(8);
      chk("trig_after_burst", 32'(trig_cnt), 32'd1);

      // eight back-to-back words -> two bursts
      base = trig_cnt;
      for (int i = 0; i < 8; i++) push_word(16'hA000 + 16'(i));
      wait_trig(base + 1);
      repeat (BL) pop_word();
      wait_trig(base + 2);
      repeat (BL) pop_word();
      idle(8);
      chk("trig_two_bursts", 32'(trig_cnt), 32'(base + 2));

      // fill to full, overflow, full + simultaneous push/pop, drain
      for (int i = 0; i < DEPTH; i++) push_word(16'(i * 7 + 3));
      push_word(16'hDEAD);
      step(1'b1, 16'hBEEF, 1'b1);
      for (int i = 0; i < DEPTH - 1; i++) pop_word();

      // underflow: wr_data holds the last popped word
      pop_word();
      chk("udf_hold", 32'(wr_data), 32'(last_pop));
      // push+pop while empty: push lands, pop is an underflow
      step(1'b1, 16'hABCD, 1'b1);
      pop_word();

      do_reset("rst2");

      // pointer wrap with a shallow stream, no flags expected
      for (int i = 0; i < 1100; i++) step(1'b1, 16'(i * 13 + 1), (i > 0));
      pop_word();
      idle(2);

      // reset in the middle of a burst
      base = trig_cnt;
      for (int i = 0; i < BL; i++) push_word(16'h5100 + 16'(i));
      wait_trig(base + 1);
      pop_word();
      pop_word();
      do_reset("rst_mid");
      for (int i = 0; i < BL; i++) push_word(16'h6100 + 16'(i));
      wait_trig(base + 2);
      repeat (BL) pop_word();
      idle(4);
      chk("trig_after_rst", 32'(trig_cnt), 32'(base + 2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
